// File: rtl/hazard_controller_if.sv
// Bundle between the pipeline datapath and the hazard controller: hazard
// inputs, per-register stall/flush controls, state and status observables.
interface hazard_controller_if #(
    parameter int CNT_WIDTH = 32
);
    logic [4:0]           if_id_rs1;
    logic [4:0]           if_id_rs2;
    logic                 if_id_uses_rs1;
    logic                 if_id_uses_rs2;
    logic                 id_ex_mem_read;
    logic [4:0]           id_ex_rd;
    logic                 branch_taken;
    logic                 mem_access;
    logic                 mem_ready;
    logic                 pc_write;
    logic                 if_id_write;
    logic                 if_id_flush;
    logic                 id_ex_bubble;
    logic                 ex_mem_flush;
    logic                 ex_mem_hold;
    logic                 mem_wb_bubble;
    logic [1:0]           state;
    logic [CNT_WIDTH-1:0] stall_count;
    logic [CNT_WIDTH-1:0] flush_count;
    logic                 mem_error;

    modport master (
        output if_id_rs1, if_id_rs2, if_id_uses_rs1, if_id_uses_rs2,
               id_ex_mem_read, id_ex_rd, branch_taken, mem_access, mem_ready,
        input  pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_flush,
               ex_mem_hold, mem_wb_bubble, state, stall_count, flush_count,
               mem_error
    );

    modport slave (
        input  if_id_rs1, if_id_rs2, if_id_uses_rs1, if_id_uses_rs2,
               id_ex_mem_read, id_ex_rd, branch_taken, mem_access, mem_ready,
        output pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_flush,
               ex_mem_hold, mem_wb_bubble, state, stall_count, flush_count,
               mem_error
    );
endinterface

// File: rtl/hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, taken-branch
// squash, memory-wait freeze, saturating perf counters and a sticky timeout flag.
module hazard_controller #(
    parameter int CNT_WIDTH  = 32,
    parameter int WAIT_LIMIT = 16
) (
    input logic                clk,
    input logic                reset,
    hazard_controller_if.slave hz
);
    localparam int WW = $clog2(WAIT_LIMIT + 1);
    localparam logic [WW-1:0] WAIT_MAX  = WW'(WAIT_LIMIT);
    localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_LIMIT - 1);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        FLUSH      = 2'd2,
        MEM_WAIT   = 2'd3
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [WW-1:0]        wait_cnt;
    logic [CNT_WIDTH-1:0] stall_cnt;
    logic [CNT_WIDTH-1:0] flush_cnt;
    logic                 mem_err;

    logic rs_match;
    logic mem_wait;
    logic flush_ev;
    logic load_use;
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_bubble;
    logic ex_mem_flush;
    logic ex_mem_hold;
    logic mem_wb_bubble;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign rs_match = (hz.if_id_uses_rs1 && (hz.if_id_rs1 == hz.id_ex_rd)) ||
                      (hz.if_id_uses_rs2 && (hz.if_id_rs2 == hz.id_ex_rd));
    assign mem_wait = hz.mem_access && !hz.mem_ready;
    // A stale branch right after a flush and a repeat stall right after a stall are ignored.
    assign flush_ev = hz.branch_taken && (state_q != FLUSH);
    assign load_use = hz.id_ex_mem_read && (hz.id_ex_rd != 5'd0) && rs_match &&
                      (state_q != LOAD_STALL);

    always_comb begin
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_bubble  = 1'b0;
        ex_mem_flush  = 1'b0;
        ex_mem_hold   = 1'b0;
        mem_wb_bubble = 1'b0;
        state_d       = RUN;
        if (reset) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_bubble  = 1'b1;
            ex_mem_flush  = 1'b1;
            mem_wb_bubble = 1'b1;
        end else if (mem_wait) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            ex_mem_hold   = 1'b1;
            mem_wb_bubble = 1'b1;
            state_d       = MEM_WAIT;
        end else if (flush_ev) begin
            if_id_flush   = 1'b1;
            id_ex_bubble  = 1'b1;
            ex_mem_flush  = 1'b1;
            state_d       = FLUSH;
        end else if (load_use) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_bubble  = 1'b1;
            state_d       = LOAD_STALL;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt  <= '0;
            mem_err   <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (mem_wait) begin
                if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 1'b1;
                if (wait_cnt == WAIT_LAST) mem_err <= 1'b1;
            end else begin
                wait_cnt <= '0;
            end
            if (!pc_write) stall_cnt <= sat_inc(stall_cnt);
            if (if_id_flush) flush_cnt <= sat_inc(flush_cnt);
        end
    end

    assign hz.pc_write      = pc_write;
    assign hz.if_id_write   = if_id_write;
    assign hz.if_id_flush   = if_id_flush;
    assign hz.id_ex_bubble  = id_ex_bubble;
    assign hz.ex_mem_flush  = ex_mem_flush;
    assign hz.ex_mem_hold   = ex_mem_hold;
    assign hz.mem_wb_bubble = mem_wb_bubble;
    assign hz.state         = state_q;
    assign hz.stall_count   = stall_cnt;
    assign hz.flush_count   = flush_cnt;
    assign hz.mem_error     = mem_err;
endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: an action-level model checked every
// cycle, plus pinned literal expectations for state, counters and error flag.
module tb_hazard_controller;
    localparam int CW   = 4;
    localparam int WL   = 4;
    localparam int CMAX = (1 << CW) - 1;

    // {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_flush, ex_mem_hold, mem_wb_bubble}
    localparam logic [6:0] OUT_TBL [4] = '{7'b1100000, 7'b0001000, 7'b1111100, 7'b0000011};
    localparam logic [6:0] RST_OUT = 7'b0011101;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    hazard_controller_if #(.CNT_WIDTH(CW)) hz ();

    hazard_controller #(.CNT_WIDTH(CW), .WAIT_LIMIT(WL)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz.slave)
    );

    int   m_prev  = 0;
    int   m_wait  = 0;
    int   m_stall = 0;
    int   m_flush = 0;
    logic m_err   = 1'b0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int pin_at = -1;
    int pin_state, pin_stall, pin_flush, pin_err;

    // 0 = run, 1 = load-use stall, 2 = flush, 3 = memory wait
    function automatic int action();
        bit mw, fl, lu;
        mw = hz.mem_access && !hz.mem_ready;
        fl = hz.branch_taken && (m_prev != 2);
        lu = hz.id_ex_mem_read && (hz.id_ex_rd != 0) && (m_prev != 1) &&
             ((hz.if_id_uses_rs1 && hz.if_id_rs1 == hz.id_ex_rd) ||
              (hz.if_id_uses_rs2 && hz.if_id_rs2 == hz.id_ex_rd));
        if (mw) return 3;
        if (fl) return 2;
        if (lu) return 1;
        return 0;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_prev  <= 0;
            m_wait  <= 0;
            m_stall <= 0;
            m_flush <= 0;
            m_err   <= 1'b0;
        end else begin
            m_prev <= action();
            if (action() == 3) begin
                m_wait <= (m_wait < WL) ? m_wait + 1 : m_wait;
                if (m_wait + 1 >= WL) m_err <= 1'b1;
            end else begin
                m_wait <= 0;
            end
            if (action() == 1 || action() == 3) m_stall <= (m_stall == CMAX) ? m_stall : m_stall + 1;
            if (action() == 2) m_flush <= (m_flush == CMAX) ? m_flush : m_flush + 1;
        end
    end

    task automatic chk(input string name, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s cycle=%0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    initial begin
        logic [6:0] got_ctrl;
        logic [6:0] exp_ctrl;
        forever begin
            @(negedge clk);
            cyc++;
            got_ctrl = {hz.pc_write, hz.if_id_write, hz.if_id_flush, hz.id_ex_bubble,
                        hz.ex_mem_flush, hz.ex_mem_hold, hz.mem_wb_bubble};
            exp_ctrl = reset ? RST_OUT : OUT_TBL[action()];
            chk("controls", got_ctrl, exp_ctrl);
            chk("state", hz.state, m_prev);
            chk("stall_count", hz.stall_count, m_stall);
            chk("flush_count", hz.flush_count, m_flush);
            chk("mem_error", hz.mem_error, m_err);
            if (cyc == pin_at) begin
                chk("pin_state", hz.state, pin_state);
                chk("pin_stall_count", hz.stall_count, pin_stall);
                chk("pin_flush_count", hz.flush_count, pin_flush);
                chk("pin_mem_error", hz.mem_error, pin_err);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pin(input int s, input int sc, input int fc, input int e);
        pin_state = s;
        pin_stall = sc;
        pin_flush = fc;
        pin_err   = e;
        pin_at    = cyc + 1;
    endtask

    task automatic drive(input int mr, input int rd, input int r1, input int u1,
                         input int r2, input int u2, input int br, input int ma,
                         input int rdy);
        hz.id_ex_mem_read = (mr != 0);
        hz.id_ex_rd       = 5'(rd);
        hz.if_id_rs1      = 5'(r1);
        hz.if_id_uses_rs1 = (u1 != 0);
        hz.if_id_rs2      = 5'(r2);
        hz.if_id_uses_rs2 = (u2 != 0);
        hz.branch_taken   = (br != 0);
        hz.mem_access     = (ma != 0);
        hz.mem_ready      = (rdy != 0);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        idle();
        tick();
        pin(0, 0, 0, 0);
        tick();
        reset = 1'b0;
        pin(0, 0, 0, 0);

        // load-use on rs1, held two cycles: one bubble only
        tick(); drive(1, 5, 5, 1, 0, 0, 0, 0, 0);
        tick(); pin(1, 1, 0, 0);
        tick(); drive(1, 0, 0, 1, 0, 0, 0, 0, 0); pin(0, 1, 0, 0);
        tick(); drive(1, 7, 3, 1, 7, 0, 0, 0, 0); pin(0, 1, 0, 0);
        tick(); drive(1, 7, 3, 1, 7, 1, 0, 0, 0);
        tick(); idle(); pin(1, 2, 0, 0);

        // taken branch beats a simultaneous load-use; held branch is stale
        tick(); drive(1, 5, 5, 1, 0, 0, 1, 0, 0); pin(0, 2, 0, 0);
        tick(); drive(0, 0, 0, 0, 0, 0, 1, 0, 0); pin(2, 2, 1, 0);
        tick(); idle(); pin(0, 2, 1, 0);

        // memory wait with pending branch; flush fires on the ready cycle
        tick(); drive(0, 0, 0, 0, 0, 0, 1, 1, 0);
        tick();
        tick();
        tick(); drive(0, 0, 0, 0, 0, 0, 1, 1, 1); pin(3, 5, 1, 0);
        tick(); idle(); pin(2, 5, 2, 0);

        // timeout at WAIT_LIMIT consecutive waits, sticky afterwards
        tick(); drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        tick();
        tick();
        tick(); pin(3, 8, 2, 0);
        tick(); drive(0, 0, 0, 0, 0, 0, 0, 1, 1); pin(3, 9, 2, 1);
        tick(); idle(); pin(0, 9, 2, 1);

        // long wait drives stall_count into saturation
        tick(); drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        repeat (7) tick();
        tick(); idle(); pin(3, CMAX, 2, 1);
        tick(); pin(0, CMAX, 2, 1);

        // asynchronous reset in the middle of a memory wait
        tick(); drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        tick();
        tick();
        tick(); reset = 1'b1; pin(0, 0, 0, 0);
        @(negedge clk);
        #2;
        reset = 1'b0;
        idle();
        tick(); pin(0, 0, 0, 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hazard_controller.md
# hazard_controller

Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Detects load-use hazards between the ID and EX stages.
- Squashes wrong-path instructions when a branch resolves taken in the MEM stage.
- Freezes the pipeline while a multi-cycle data memory access is outstanding.
- Emits per-register write-enable/flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Keeps saturating performance counters and a sticky memory-timeout error flag.

## Interface

Parameters:
- CNT_WIDTH, 32, width of `stall_count` and `flush_count`
- WAIT_LIMIT, 16, consecutive memory-wait cycles after which `mem_error` sets (≥1)

Ports (name, direction, width, meaning):
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- if_id_rs1  in  5  rs1 of instruction in ID
- if_id_rs2  in  5  rs2 of instruction in ID
- if_id_uses_rs1  in  1  ID instruction reads rs1
- if_id_uses_rs2  in  1  ID instruction reads rs2 (R/S/SB types)
- id_ex_mem_read  in  1  EX instruction is a load
- id_ex_rd  in  5  destination of EX instruction
- branch_taken  in  1  EX_MEM_Branch & EX_MEM_Zero
- mem_access  in  1  EX_MEM_MemRead | EX_MEM_MemWrite
- mem_ready  in  1  data memory completes access this cycle
- pc_write  out  1  PC register load enable
- if_id_write  out  1  IF/ID load enable
- if_id_flush  out  1  IF/ID clears to NOP on this edge
- id_ex_bubble  out  1  ID/EX control bits clear on this edge
- ex_mem_flush  out  1  EX/MEM control bits clear on this edge
- ex_mem_hold  out  1  EX/MEM and ID/EX retain contents
- mem_wb_bubble  out  1  MEM/WB control bits clear on this edge
- state  out  2  current FSM state
- stall_count  out  CNT_WIDTH  cycles with pc_write=0
- flush_count  out  CNT_WIDTH  taken-branch flush events
- mem_error  out  1  sticky: wait reached WAIT_LIMIT

## Operation

FSM states, where the state names the action performed in the previous cycle:
- RUN = 0
- LOAD_STALL = 1
- FLUSH = 2
- MEM_WAIT = 3

Events, evaluated combinationally each cycle in priority order:
1. **mem_wait** = `mem_access & ~mem_ready`
   - Outputs: `pc_write=0`, `if_id_write=0`, `ex_mem_hold=1`, `mem_wb_bubble=1`; all other flush/bubble outputs = 0.
   - Next state = MEM_WAIT.
2. **flush** = `branch_taken & (state != FLUSH)`
   - Outputs: `pc_write=1` (the datapath mux selects the branch target), `if_id_flush=1`, `id_ex_bubble=1`, `ex_mem_flush=1`.
   - Next state = FLUSH.
3. **load_use** = `id_ex_mem_read & (id_ex_rd != 0) & ((if_id_uses_rs1 & if_id_rs1 == id_ex_rd) | (if_id_uses_rs2 & if_id_rs2 == id_ex_rd)) & (state != LOAD_STALL)`
   - Outputs: `pc_write=0`, `if_id_write=0`, `id_ex_bubble=1`.
   - Next state = LOAD_STALL.
4. **None of the above**
   - Outputs: `pc_write=1`, `if_id_write=1`, all flush/bubble/hold outputs = 0.
   - Next state = RUN.

Suppression rules:
- `state == LOAD_STALL` suppresses a second consecutive load-use stall, so each load-use stall is exactly one cycle.
- `state == FLUSH` ignores `branch_taken`, which is stale because EX/MEM was just flushed.

Wait counter:
- `wait_cnt` (internal, clog2(WAIT_LIMIT+1) bits) increments on each mem_wait cycle.
- It clears on any non-mem_wait cycle.
- It saturates at WAIT_LIMIT.
- When it increments to WAIT_LIMIT, `mem_error` sets at that edge and holds until reset.

Counters:
- `stall_count` increments on each cycle with `pc_write=0` (load_use or mem_wait).
- `flush_count` increments on each flush cycle.
- Both saturate at all-ones; they never wrap.

Simultaneous events:
- mem_wait + branch_taken: hold wins; the flush occurs on the first cycle `mem_ready=1`.
- flush + load_use: flush wins, because the hazardous ID instruction is being squashed; `stall_count` does not increment.

## Timing

- All control outputs (`pc_write` through `mem_wb_bubble`) are combinational from the inputs and `state`, valid in the same cycle.
- `state`, `wait_cnt`, counters and `mem_error` update on the rising edge of `clk`.
- Reset is asynchronous: on assertion `state=RUN`, `wait_cnt=0`, `stall_count=0`, `flush_count=0`, `mem_error=0` immediately.
- Control outputs while reset is high: `pc_write=0`, `if_id_write=0`, `if_id_flush=1`, `id_ex_bubble=1`, `ex_mem_flush=1`, `ex_mem_hold=0`, `mem_wb_bubble=1`.
- Reset mid-MEM_WAIT or mid-stall abandons the operation; no counter update occurs on that edge.
- Load-use stall latency: exactly 1 bubble cycle.
- Branch penalty: 3 squashed instructions, one cycle of controls.
- Memory-wait freeze lasts exactly as many cycles as `mem_ready` stays low.
- `id_ex_rd == 0` never causes a stall.

## Test plan

- **Reset:** after 3 mem_wait cycles, assert reset for half a cycle → `state=0`, counters=0, `mem_error=0` before the next edge; controls equal the reset values.
- **Load-use:** `id_ex_mem_read=1`, `id_ex_rd=5`, `if_id_rs1=5`, `if_id_uses_rs1=1`, held 2 cycles →
  - cycle 1: `pc_write=0`, `if_id_write=0`, `id_ex_bubble=1`;
  - cycle 2: `state=1`, `pc_write=1`;
  - `stall_count=1`.
- **x0 / unused-operand cases:**
  - `id_ex_rd=0`, `if_id_rs1=0` → no stall.
  - `id_ex_rd=7`, `if_id_rs2=7`, `if_id_uses_rs2=0` → no stall.
- **Branch flush:** `branch_taken=1` together with a load-use match →
  - `if_id_flush=1`, `id_ex_bubble=1`, `ex_mem_flush=1`, `pc_write=1`;
  - `flush_count=1`, `stall_count=0`;
  - `branch_taken` held into the next cycle is ignored (`state=2`).
- **Memory wait:** `mem_access=1`, `mem_ready=0` for 3 cycles with `branch_taken=1` →
  - `ex_mem_hold=1`, `mem_wb_bubble=1`, `pc_write=0` for 3 cycles;
  - `stall_count=3`;
  - on the `mem_ready=1` cycle, the flush asserts.
- **Timeout (WAIT_LIMIT=4):** 4 not-ready cycles → `mem_error=1` after the 4th edge; it stays 1 after `mem_ready=1`; only reset clears it.
